mem_io_responder: RTL and testbench

- Memory-side responder for the CPU's byte-wide memory bus (mem_a / mem_wr / mem_dout out of the CPU, mem_din / io_buffer_full back into it).
- Provides a byte RAM with 1-cycle read latency.
- Provides a memory-mapped I/O window at 0x30000: UART TX FIFO, UART RX FIFO and a halt register.
- Sits between cpu and the board/testbench UART, replacing ad-hoc RAM models in simulation and FPGA top.

---
 rtl/riscv_mem_pkg.sv | 13 +
 rtl/mem_io_responder_if.sv | 27 ++
 rtl/byte_fifo.sv | 46 ++++
 rtl/mem_io_responder.sv | 101 ++++++++++
 tb/tb_mem_io_responder.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared constants for the CPU byte-bus memory/IO responder.
package riscv_mem_pkg;
    localparam int unsigned ADDR_W_DEF   = 17;
    localparam int unsigned TX_DEPTH_DEF = 8;
    localparam int unsigned RX_DEPTH_DEF = 8;
    localparam int unsigned BUS_A_W      = 32;
    localparam int unsigned DATA_W       = 8;
    localparam int unsigned DEC_W        = 18;

    localparam logic [DEC_W-1:0] IO_UART_ADDR = 18'h30000;
    localparam logic [DEC_W-1:0] IO_HALT_ADDR = 18'h30004;
    localparam logic [1:0]       IO_SEL       = 2'b11;
endpackage

// File: rtl/mem_io_responder_if.sv
// CPU byte bus plus UART TX/RX handshakes and halt flag.
interface mem_io_responder_if;
    import riscv_mem_pkg::*;

    logic [BUS_A_W-1:0] mem_a;
    logic               mem_wr;
    logic [DATA_W-1:0]  mem_dout;
    logic [DATA_W-1:0]  mem_din;
    logic               io_buffer_full;
    logic               tx_valid;
    logic [DATA_W-1:0]  tx_data;
    logic               tx_ready;
    logic               rx_valid;
    logic [DATA_W-1:0]  rx_data;
    logic               rx_ready;
    logic               halt;

    modport master (
        output mem_a, mem_wr, mem_dout, tx_ready, rx_valid, rx_data,
        input  mem_din, io_buffer_full, tx_valid, tx_data, rx_ready, halt
    );

    modport slave (
        input  mem_a, mem_wr, mem_dout, tx_ready, rx_valid, rx_data,
        output mem_din, io_buffer_full, tx_valid, tx_data, rx_ready, halt
    );
endinterface

// File: rtl/byte_fifo.sv
// Small synchronous FIFO with wrap-bit pointers; pop frees a slot for a same-cycle push.
module byte_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned W     = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic [$clog2(DEPTH):0]     count_nxt_c
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [W-1:0]  mem [DEPTH];
    logic          do_push, do_pop;

    assign empty       = (wr_ptr == rd_ptr);
    assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count       = wr_ptr - rd_ptr;
    assign do_pop      = pop && !empty;
    assign do_push     = push && (!full || do_pop);
    assign count_nxt_c = count + PW'(do_push) - PW'(do_pop);
    assign head        = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Storage is not reset; only the pointers define valid contents.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/mem_io_responder.sv
// Byte RAM with 1-cycle read latency plus UART FIFOs and halt register at 0x30000.
module mem_io_responder
    import riscv_mem_pkg::*;
#(
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned TX_DEPTH = TX_DEPTH_DEF,
    parameter int unsigned RX_DEPTH = RX_DEPTH_DEF
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    mem_io_responder_if.slave bus
);
    localparam int unsigned TX_CW = $clog2(TX_DEPTH) + 1;
    localparam int unsigned RX_CW = $clog2(RX_DEPTH) + 1;
    localparam logic [TX_CW-1:0] TX_AF = TX_CW'(TX_DEPTH - 2);

    logic [DATA_W-1:0] ram [2**ADDR_W];

    logic [DEC_W-1:0]  dec_a;
    logic [ADDR_W-1:0] ram_idx;
    logic              io_sel;
    logic              ram_we, tx_push, rx_pop;
    logic [DATA_W-1:0] din_nxt, mem_din_q;
    logic              halt_q, io_full_q;

    logic [DATA_W-1:0] rx_head;
    logic              rx_full, rx_empty, tx_empty;
    logic [TX_CW-1:0]  tx_count_nxt;
    logic [TX_CW-1:0]  unused_tx_count;
    logic [RX_CW-1:0]  unused_rx_count, unused_rx_count_nxt;
    logic              unused_tx_full;
    logic              unused_hi;

    assign dec_a     = bus.mem_a[DEC_W-1:0];
    assign ram_idx   = bus.mem_a[ADDR_W-1:0];
    assign unused_hi = ^bus.mem_a[BUS_A_W-1:DEC_W];
    assign io_sel    = (dec_a[DEC_W-1:DEC_W-2] == IO_SEL);
    assign ram_we    = rdy_in && bus.mem_wr && !io_sel;
    assign tx_push   = rdy_in && bus.mem_wr && io_sel && (dec_a == IO_UART_ADDR);
    assign rx_pop    = rdy_in && !bus.mem_wr && io_sel && (dec_a == IO_UART_ADDR);

    byte_fifo #(.DEPTH(TX_DEPTH), .W(DATA_W)) u_tx_fifo (
        .clk         (clk_in),
        .rst_n       (rst_in),
        .push        (tx_push),
        .pop         (bus.tx_ready),
        .din         (bus.mem_dout),
        .head        (bus.tx_data),
        .full        (unused_tx_full),
        .empty       (tx_empty),
        .count       (unused_tx_count),
        .count_nxt_c (tx_count_nxt)
    );

    // rx_ready gates the push so a full RX FIFO never accepts, even on a read-pop.
    byte_fifo #(.DEPTH(RX_DEPTH), .W(DATA_W)) u_rx_fifo (
        .clk         (clk_in),
        .rst_n       (rst_in),
        .push        (bus.rx_valid && !rx_full),
        .pop         (rx_pop),
        .din         (bus.rx_data),
        .head        (rx_head),
        .full        (rx_full),
        .empty       (rx_empty),
        .count       (unused_rx_count),
        .count_nxt_c (unused_rx_count_nxt)
    );

    assign bus.tx_valid       = !tx_empty;
    assign bus.rx_ready       = !rx_full;
    assign bus.mem_din        = mem_din_q;
    assign bus.halt           = halt_q;
    assign bus.io_buffer_full = io_full_q;

    always_comb begin
        din_nxt = mem_din_q;
        if (rdy_in && !bus.mem_wr) begin
            if (!io_sel)                    din_nxt = ram[ram_idx];
            else if (dec_a == IO_UART_ADDR) din_nxt = rx_empty ? '0 : rx_head;
            else if (dec_a == IO_HALT_ADDR) din_nxt = {7'b0, rx_empty};
            else                            din_nxt = '0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            mem_din_q <= '0;
            halt_q    <= 1'b0;
            io_full_q <= 1'b0;
        end else begin
            mem_din_q <= din_nxt;
            io_full_q <= (tx_count_nxt >= TX_AF);
            if (rdy_in && bus.mem_wr && io_sel && (dec_a == IO_HALT_ADDR)) halt_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (ram_we) ram[ram_idx] <= bus.mem_dout;
    end
endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: RAM, TX/RX FIFOs, flags, rdy gating, reset.
module tb_mem_io_responder;
    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    logic rdy_in = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [7:0] rd;

    mem_io_responder_if bus ();

    mem_io_responder dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [7:0] d, input logic r);
        rdy_in = r; bus.mem_a = a; bus.mem_wr = 1'b1; bus.mem_dout = d;
        tick();
        rdy_in = 1'b0; bus.mem_wr = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [7:0] d);
        rdy_in = 1'b1; bus.mem_a = a; bus.mem_wr = 1'b0;
        tick();
        rdy_in = 1'b0;
        d = bus.mem_din;
    endtask

    initial begin
        bus.mem_a = '0; bus.mem_wr = 1'b0; bus.mem_dout = '0;
        bus.tx_ready = 1'b0; bus.rx_valid = 1'b0; bus.rx_data = '0;
        #12;
        check("rst_mem_din", 32'(bus.mem_din), 0);
        check("rst_io_full", 32'(bus.io_buffer_full), 0);
        check("rst_tx_valid", 32'(bus.tx_valid), 0);
        check("rst_rx_ready", 32'(bus.rx_ready), 1);
        check("rst_halt", 32'(bus.halt), 0);
        tick();
        rst_in = 1'b1;
        tick();

        // RAM write then back-to-back read
        bus_write(32'h10, 8'hA5, 1'b1);
        bus_read(32'h10, rd);
        check("ram_raw", 32'(rd), 32'hA5);
        bus_write(32'h11, 8'h5A, 1'b1);
        bus_read(32'h11, rd);
        check("ram_raw2", 32'(rd), 32'h5A);
        bus_read(32'h10, rd);
        check("ram_reread", 32'(rd), 32'hA5);

        // TX head held while tx_ready low, then drained
        bus_write(32'h30000, 8'h48, 1'b1);
        bus_write(32'h30000, 8'h69, 1'b1);
        tick(); tick();
        check("tx_valid_held", 32'(bus.tx_valid), 1);
        check("tx_head_held", 32'(bus.tx_data), 32'h48);
        bus.tx_ready = 1'b1;
        tick();
        check("tx_second", 32'(bus.tx_data), 32'h69);
        check("tx_valid_mid", 32'(bus.tx_valid), 1);
        tick();
        check("tx_drained", 32'(bus.tx_valid), 0);
        bus.tx_ready = 1'b0;

        // Nearly-full flag, overflow drop and drain hysteresis
        for (int i = 1; i <= 6; i++) begin
            bus_write(32'h30000, 8'(i), 1'b1);
            if (i == 5) check("af_at5", 32'(bus.io_buffer_full), 0);
        end
        check("af_at6", 32'(bus.io_buffer_full), 1);
        bus_write(32'h30000, 8'h07, 1'b1);
        bus_write(32'h30000, 8'h08, 1'b1);
        bus_write(32'h30000, 8'hEE, 1'b1);
        check("af_full_head", 32'(bus.tx_data), 32'h01);
        check("af_full_flag", 32'(bus.io_buffer_full), 1);
        for (int k = 0; k < 8; k++) begin
            bus.tx_ready = 1'b1;
            check($sformatf("drain_data%0d", k), 32'(bus.tx_data), 32'(k + 1));
            tick();
            bus.tx_ready = 1'b0;
            check($sformatf("drain_flag%0d", k), 32'(bus.io_buffer_full), 32'((7 - k) >= 6));
        end
        check("drain_empty", 32'(bus.tx_valid), 0);

        // RX FIFO push and read side effects
        bus.rx_valid = 1'b1; bus.rx_data = 8'h31;
        tick();
        bus.rx_data = 8'h32;
        tick();
        bus.rx_valid = 1'b0;
        bus_read(32'h30004, rd);
        check("rx_stat_ne", 32'(rd), 0);
        bus_read(32'h30000, rd);
        check("rx_pop1", 32'(rd), 32'h31);
        bus_read(32'h30000, rd);
        check("rx_pop2", 32'(rd), 32'h32);
        bus_read(32'h30000, rd);
        check("rx_pop_empty", 32'(rd), 0);
        bus_read(32'h30004, rd);
        check("rx_stat_e", 32'(rd), 1);

        // RX full: rx_ready drops and extra byte is refused
        bus.rx_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.rx_data = 8'(8'hA0 + i);
            tick();
        end
        check("rx_full_ready", 32'(bus.rx_ready), 0);
        bus.rx_data = 8'hFF;
        tick();
        bus.rx_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus_read(32'h30000, rd);
            check($sformatf("rx_full_pop%0d", i), 32'(rd), 32'(8'hA0 + i));
        end
        check("rx_ready_again", 32'(bus.rx_ready), 1);
        bus_read(32'h30000, rd);
        check("rx_no_extra", 32'(rd), 0);

        // rdy_in gating
        bus_write(32'h20, 8'h77, 1'b1);
        bus_write(32'h30004, 8'h00, 1'b0);
        check("rdy0_halt", 32'(bus.halt), 0);
        bus_write(32'h20, 8'h99, 1'b0);
        bus_read(32'h20, rd);
        check("rdy0_ram", 32'(rd), 32'h77);
        bus.mem_a = 32'h10; bus.mem_wr = 1'b0; rdy_in = 1'b0;
        tick();
        check("rdy0_din_hold", 32'(bus.mem_din), 32'h77);
        bus_read(32'h30008, rd);
        check("io_other_rd", 32'(rd), 0);
        bus_write(32'h30004, 8'h00, 1'b1);
        check("halt_set", 32'(bus.halt), 1);
        tick();
        check("halt_sticky", 32'(bus.halt), 1);

        // Async reset mid-cycle with TX bytes pending
        bus_write(32'h30000, 8'h11, 1'b1);
        bus_write(32'h30000, 8'h22, 1'b1);
        bus_write(32'h30000, 8'h33, 1'b1);
        check("pre_rst_valid", 32'(bus.tx_valid), 1);
        #3;
        rst_in = 1'b0;
        #1;
        check("async_tx_valid", 32'(bus.tx_valid), 0);
        check("async_halt", 32'(bus.halt), 0);
        tick();
        rst_in = 1'b1;
        tick();
        check("post_rst_full", 32'(bus.io_buffer_full), 0);
        check("post_rst_rx_ready", 32'(bus.rx_ready), 1);
        check("post_rst_din", 32'(bus.mem_din), 0);
        check("post_rst_tx_valid", 32'(bus.tx_valid), 0);
        bus_read(32'h10, rd);
        check("ram_kept", 32'(rd), 32'hA5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
